// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C transaction arbiter and its helpers.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_ABORT  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ANACK = 2'b01;
  localparam logic [1:0] ERR_DNACK = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping, returned both one-hot and as a binary index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int w_k;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_k     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_k = (int'(i_ptr) + i) % N_REQ;
      if (!o_any && i_req[w_k]) begin
        o_grant[w_k] = 1'b1;
        o_idx        = PTR_W'(w_k);
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master byte engine among N_REQ requesters: round-robin grant,
// descriptor latch, byte routing while running, and status/ack back to the owner.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [N_REQ*I2C_ADDR_W-1:0] i_addr,
  input  logic [N_REQ-1:0]            i_rw,
  input  logic [N_REQ*LEN_W-1:0]      i_len,
  input  logic [N_REQ*DATA_W-1:0]     i_wdata,
  output logic [N_REQ-1:0]            o_grant,
  output logic [N_REQ-1:0]            o_wready,
  output logic [N_REQ-1:0]            o_rvalid,
  output logic [DATA_W-1:0]           o_rdata,
  output logic [N_REQ-1:0]            o_ack,
  output logic [1:0]                  o_err,
  output logic                        o_m_start,
  output logic [I2C_ADDR_W-1:0]       o_m_addr,
  output logic                        o_m_rw,
  output logic [LEN_W-1:0]            o_m_len,
  output logic [DATA_W-1:0]           o_m_wdata,
  output logic                        o_m_abort,
  input  logic                        i_m_wreq,
  input  logic                        i_m_rvalid,
  input  logic [DATA_W-1:0]           i_m_rdata,
  input  logic                        i_m_done,
  input  logic [1:0]                  i_m_nack
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  state_t                  r_state;
  logic [N_REQ-1:0]        r_grant;
  logic [N_REQ-1:0]        r_rvalid;
  logic [N_REQ-1:0]        r_ack;
  logic [PTR_W-1:0]        r_ptr;
  logic [PTR_W-1:0]        r_own;
  logic [WD_W-1:0]         r_wd;
  logic [DATA_W-1:0]       r_rdata;
  logic [1:0]              r_err;
  logic                    r_m_start;
  logic                    r_m_abort;
  logic [I2C_ADDR_W-1:0]   r_m_addr;
  logic                    r_m_rw;
  logic [LEN_W-1:0]        r_m_len;

  logic [N_REQ-1:0]        w_win;
  logic [PTR_W-1:0]        w_win_idx;
  logic                    w_any;
  logic [I2C_ADDR_W-1:0]   w_addr;
  logic                    w_rw;
  logic [LEN_W-1:0]        w_len;
  logic [DATA_W-1:0]       w_own_wdata;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_win),
    .o_idx   (w_win_idx),
    .o_any   (w_any)
  );

  // Descriptor of the arbitration winner, and write byte of the current owner.
  always_comb begin
    w_addr      = i_addr[int'(w_win_idx)*I2C_ADDR_W +: I2C_ADDR_W];
    w_rw        = i_rw[w_win_idx];
    w_len       = i_len[int'(w_win_idx)*LEN_W +: LEN_W];
    w_own_wdata = i_wdata[int'(r_own)*DATA_W +: DATA_W];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_rvalid  <= '0;
      r_ack     <= '0;
      r_ptr     <= '0;
      r_own     <= '0;
      r_wd      <= '0;
      r_rdata   <= '0;
      r_err     <= ERR_OK;
      r_m_start <= 1'b0;
      r_m_abort <= 1'b0;
      r_m_addr  <= '0;
      r_m_rw    <= 1'b0;
      r_m_len   <= '0;
    end else begin
      r_m_start <= 1'b0;
      r_m_abort <= 1'b0;
      r_rvalid  <= '0;
      r_ack     <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant  <= w_win;
            r_own    <= w_win_idx;
            r_m_addr <= w_addr;
            r_m_rw   <= w_rw;
            r_m_len  <= w_len;
            r_wd     <= '0;
            // A zero-length descriptor never reaches the bus; it is bounced
            // straight back as an address NACK.
            if (w_len == '0) begin
              r_err   <= ERR_ANACK;
              r_ack   <= w_win;
              r_state <= ST_FINISH;
            end else begin
              r_m_start <= 1'b1;
              r_state   <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          r_wd    <= r_wd + 1'b1;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_wd <= r_wd + 1'b1;
          if (i_m_rvalid) begin
            r_rdata  <= i_m_rdata;
            r_rvalid <= r_grant;
          end
          // Completion outranks a watchdog expiry landing in the same cycle.
          if (i_m_done) begin
            r_err   <= i_m_nack;
            r_ack   <= r_grant;
            r_state <= ST_FINISH;
          end else if (r_wd == WD_LAST) begin
            r_m_abort <= 1'b1;
            r_state   <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (i_m_done) begin
            r_err   <= ERR_TMO;
            r_ack   <= r_grant;
            r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_grant <= '0;
          r_err   <= ERR_OK;
          r_ptr   <= (r_own == PTR_LAST) ? '0 : r_own + 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_grant   = r_grant;
  assign o_wready  = ((r_state == ST_RUN) && i_m_wreq) ? r_grant : '0;
  assign o_rvalid  = r_rvalid;
  assign o_rdata   = r_rdata;
  assign o_ack     = r_ack;
  assign o_err     = r_err;
  assign o_m_start = r_m_start;
  assign o_m_addr  = r_m_addr;
  assign o_m_rw    = r_m_rw;
  assign o_m_len   = r_m_len;
  assign o_m_wdata = (|r_grant) ? w_own_wdata : '0;
  assign o_m_abort = r_m_abort;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: emulates requesters and the bus master,
// tracks expected outputs with a timestamp-based transaction model.
module tb_i2c_txn_arbiter;
  localparam int N_REQ       = 4;
  localparam int LEN_W       = 4;
  localparam int TIMEOUT_CYC = 4096;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req, rw;
  logic [N_REQ*7-1:0]     addr;
  logic [N_REQ*LEN_W-1:0] len;
  logic [N_REQ*8-1:0]     wdata;
  logic [N_REQ-1:0]       grant, wready, rvalid, ack;
  logic [7:0]             rdata;
  logic [1:0]             err;
  logic                   m_start, m_rw, m_abort;
  logic [6:0]             m_addr;
  logic [LEN_W-1:0]       m_len;
  logic [7:0]             m_wdata;
  logic                   m_wreq, m_rvalid, m_done;
  logic [7:0]             m_rdata;
  logic [1:0]             m_nack;

  always #5 clk = ~clk;

  i2c_txn_arbiter #(.N_REQ(N_REQ), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr(addr), .i_rw(rw), .i_len(len),
    .i_wdata(wdata), .o_grant(grant), .o_wready(wready), .o_rvalid(rvalid),
    .o_rdata(rdata), .o_ack(ack), .o_err(err), .o_m_start(m_start),
    .o_m_addr(m_addr), .o_m_rw(m_rw), .o_m_len(m_len), .o_m_wdata(m_wdata),
    .o_m_abort(m_abort), .i_m_wreq(m_wreq), .i_m_rvalid(m_rvalid),
    .i_m_rdata(m_rdata), .i_m_done(m_done), .i_m_nack(m_nack)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit seen_rst = 1'b0;

  // Model: owner, age = cycles since the grant became visible, and the ages at
  // which the ack / abort must appear once they are known.
  int md_owner = -1, md_age = 0, md_end = -1, md_abort = -1, md_ptr = 0, md_rd_owner = 0;
  bit md_len0 = 1'b0, md_rdv = 1'b0;
  logic [1:0] md_err = 2'b00;
  logic [7:0] md_rdb = 8'h00;
  logic [6:0] md_addr = 7'h00;
  logic md_rw = 1'b0;
  logic [LEN_W-1:0] md_len = '0;

  int start_cnt = 0, abort_cnt = 0, wr0_cnt = 0, start_cyc = 0, abort_dist = 0;
  int ack_q[$];
  logic [7:0] rd_q[$];
  logic [1:0] err_last = 2'b00;
  logic [6:0] start_addr = 7'h00;
  logic start_rw = 1'b0;
  logic [7:0] rd_tab [3] = '{8'hA5, 8'h3C, 8'hFF};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit md_run();
    return md_owner >= 0 && md_age >= 1 && md_end < 0 && md_abort < 0;
  endfunction

  // Compare at negedge, advance the model at posedge from the inputs seen there.
  initial begin : compare
    logic [N_REQ-1:0] eg, ea, ew, er;
    bit nrdv;
    int k;
    forever begin
      @(negedge clk);
      if (seen_rst) begin
        eg = (md_owner >= 0) ? N_REQ'(1 << md_owner) : '0;
        ea = (md_owner >= 0 && md_age == md_end) ? eg : '0;
        ew = (md_run() && m_wreq) ? eg : '0;
        er = md_rdv ? N_REQ'(1 << md_rd_owner) : '0;
        chk("grant", 32'(grant), 32'(eg));
        chk("ack", 32'(ack), 32'(ea));
        chk("wready", 32'(wready), 32'(ew));
        chk("rvalid", 32'(rvalid), 32'(er));
        chk("m_start", 32'(m_start), 32'(md_owner >= 0 && md_age == 0 && !md_len0));
        chk("m_abort", 32'(m_abort), 32'(md_owner >= 0 && md_age == md_abort));
        chk("m_addr", 32'(m_addr), 32'(md_addr));
        chk("m_rw", 32'(m_rw), 32'(md_rw));
        chk("m_len", 32'(m_len), 32'(md_len));
        if (md_owner >= 0) chk("m_wdata", 32'(m_wdata), 32'(wdata[md_owner*8 +: 8]));
        else chk("m_wdata_idle", 32'(m_wdata), 32'h0);
        if (ea != 0) chk("err", 32'(err), 32'(md_err));
        if (er != 0) chk("rdata", 32'(rdata), 32'(md_rdb));
        if (m_start) begin start_cnt++; start_cyc = cyc; start_addr = m_addr; start_rw = m_rw; end
        if (m_abort) begin abort_cnt++; abort_dist = cyc - start_cyc; end
        if (wready[0]) wr0_cnt++;
        if (rvalid != 0) rd_q.push_back(rdata);
        if (ack != 0) begin
          for (int i = 0; i < N_REQ; i++) if (ack[i]) ack_q.push_back(i);
          err_last = err;
        end
      end
      @(posedge clk);
      cyc++;
      if (rst) begin
        md_owner = -1; md_ptr = 0; md_rdv = 1'b0; md_len0 = 1'b0;
        md_addr = '0; md_rw = 1'b0; md_len = '0; seen_rst = 1'b1;
      end else begin
        nrdv = 1'b0;
        if (md_owner < 0) begin
          for (int i = 0; i < N_REQ; i++) begin
            k = (md_ptr + i) % N_REQ;
            if (md_owner < 0 && req[k]) begin
              md_owner = k; md_age = 0; md_abort = -1;
              md_addr = addr[k*7 +: 7]; md_rw = rw[k]; md_len = len[k*LEN_W +: LEN_W];
              md_len0 = (md_len == '0);
              md_end = md_len0 ? 0 : -1;
              md_err = md_len0 ? 2'b01 : 2'b00;
            end
          end
        end else if (md_age == md_end) begin
          md_ptr = (md_owner + 1) % N_REQ;
          md_owner = -1;
        end else begin
          if (md_run()) begin
            if (m_rvalid) begin nrdv = 1'b1; md_rdb = m_rdata; md_rd_owner = md_owner; end
            if (m_done) begin md_end = md_age + 1; md_err = m_nack; end
            else if (md_age == TIMEOUT_CYC - 1) md_abort = TIMEOUT_CYC;
          end else if (md_abort >= 0 && md_end < 0 && m_done) begin
            md_end = md_age + 1; md_err = 2'b11;
          end
          md_age++;
        end
        md_rdv = nrdv;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input int which, input int limit, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = m_start;
        1: hit = (ack != 0);
        default: hit = m_abort;
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_%s: got no event within %0d cycles, expected one", nm, limit);
    end
  endtask

  task automatic set_desc(input int k, input logic [6:0] a, input logic r, input logic [LEN_W-1:0] l);
    addr[k*7 +: 7] = a;
    rw[k] = r;
    len[k*LEN_W +: LEN_W] = l;
  endtask

  // Plays the master for one granted transfer and returns in the cycle after the ack.
  task automatic serve(input int k, input int n, input bit rdm, input logic [1:0] nack);
    wait_for(0, 20, "start");
    tick();
    for (int i = 0; i < n; i++) begin
      if (rdm) begin m_rvalid = 1'b1; m_rdata = rd_tab[i]; end
      else begin wdata[k*8 +: 8] = 8'(32'h10 + i); m_wreq = 1'b1; end
      tick();
      m_rvalid = 1'b0; m_wreq = 1'b0;
    end
    m_done = 1'b1; m_nack = nack;
    tick();
    m_done = 1'b0; m_nack = 2'b00;
    wait_for(1, 20, "ack");
    tick();
  endtask

  initial begin : stim
    int n0, sc;
    rst = 1'b1; req = '0; rw = '0; addr = '0; len = '0; wdata = '0;
    m_wreq = 1'b0; m_rvalid = 1'b0; m_done = 1'b0; m_rdata = 8'h00; m_nack = 2'b00;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_addr", 32'(m_addr), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);

    // Single write on requester 0.
    set_desc(0, 7'h50, 1'b0, 4'd2);
    req[0] = 1'b1;
    serve(0, 2, 1'b0, 2'b00);
    req[0] = 1'b0;
    chk("t1_starts", 32'(start_cnt), 32'd1);
    chk("t1_wready0", 32'(wr0_cnt), 32'd2);
    chk("t1_addr", 32'(start_addr), 32'h50);
    chk("t1_rw", 32'(start_rw), 32'd0);
    chk("t1_acks", 32'(ack_q.size()), 32'd1);
    chk("t1_err", 32'(err_last), 32'd0);

    // Simultaneous requests 1 and 2 after reset; 1 stays asserted.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    set_desc(1, 7'h21, 1'b0, 4'd1);
    set_desc(2, 7'h22, 1'b0, 4'd1);
    req = 4'b0110;
    serve(1, 1, 1'b0, 2'b00);
    serve(2, 1, 1'b0, 2'b00);
    req[2] = 1'b0;
    serve(1, 1, 1'b0, 2'b00);
    req[1] = 1'b0;
    chk("t2_acks", 32'(ack_q.size()), 32'd4);
    chk("t2_order0", 32'(ack_q[1]), 32'd1);
    chk("t2_order1", 32'(ack_q[2]), 32'd2);
    chk("t2_order2", 32'(ack_q[3]), 32'd1);

    // Three-byte read on requester 3.
    set_desc(3, 7'h48, 1'b1, 4'd3);
    req[3] = 1'b1;
    serve(3, 3, 1'b1, 2'b00);
    req[3] = 1'b0;
    chk("t3_rcount", 32'(rd_q.size()), 32'd3);
    chk("t3_rd0", 32'(rd_q[0]), 32'hA5);
    chk("t3_rd1", 32'(rd_q[1]), 32'h3C);
    chk("t3_rd2", 32'(rd_q[2]), 32'hFF);

    // Address NACK, then a normal transfer.
    set_desc(0, 7'h11, 1'b0, 4'd1);
    req[0] = 1'b1;
    serve(0, 1, 1'b0, 2'b01);
    req[0] = 1'b0;
    chk("t4_err_nack", 32'(err_last), 32'd1);
    set_desc(2, 7'h12, 1'b0, 4'd1);
    req[2] = 1'b1;
    serve(2, 1, 1'b0, 2'b00);
    req[2] = 1'b0;
    chk("t4_err_ok", 32'(err_last), 32'd0);
    chk("t4_owner", 32'(ack_q[$]), 32'd2);

    // Watchdog expiry; the late done carries a nack code that must be ignored.
    set_desc(1, 7'h2A, 1'b0, 4'd2);
    req[1] = 1'b1;
    wait_for(0, 20, "start");
    wait_for(2, TIMEOUT_CYC + 20, "abort");
    tick();
    m_done = 1'b1; m_nack = 2'b10;
    tick();
    m_done = 1'b0; m_nack = 2'b00;
    wait_for(1, 20, "ack");
    tick();
    req[1] = 1'b0;
    chk("t5_abort_dist", 32'(abort_dist), 32'(TIMEOUT_CYC));
    chk("t5_abort_cnt", 32'(abort_cnt), 32'd1);
    chk("t5_err", 32'(err_last), 32'd3);

    // Done arriving in the last cycle before expiry wins over the abort.
    set_desc(2, 7'h2B, 1'b0, 4'd2);
    req[2] = 1'b1;
    wait_for(0, 20, "start");
    tick();
    repeat (TIMEOUT_CYC - 2) tick();
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    wait_for(1, 20, "ack");
    tick();
    req[2] = 1'b0;
    chk("t5b_abort_cnt", 32'(abort_cnt), 32'd1);
    chk("t5b_err", 32'(err_last), 32'd0);

    // Reset in the middle of a transfer, then stray master pulses while idle.
    set_desc(0, 7'h3C, 1'b0, 4'd4);
    req[0] = 1'b1;
    wait_for(0, 20, "start");
    tick(); tick();
    n0 = ack_q.size();
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    chk("t6_grant", 32'(grant), 32'h0);
    chk("t6_addr", 32'(m_addr), 32'h0);
    repeat (8) tick();
    m_done = 1'b1; m_rvalid = 1'b1; m_wreq = 1'b1; m_nack = 2'b10;
    tick();
    m_done = 1'b0; m_rvalid = 1'b0; m_wreq = 1'b0; m_nack = 2'b00;
    repeat (3) tick();
    chk("t6_no_ack", 32'(ack_q.size()), 32'(n0));
    chk("t6_no_rvalid", 32'(rd_q.size()), 32'd3);

    // Zero-length descriptor is bounced without touching the master.
    set_desc(2, 7'h33, 1'b0, 4'd0);
    sc = start_cnt;
    req[2] = 1'b1;
    wait_for(1, 20, "ack_len0");
    tick();
    req[2] = 1'b0;
    chk("t6_len0_err", 32'(err_last), 32'd1);
    chk("t6_len0_nostart", 32'(start_cnt), 32'(sc));
    chk("t6_len0_owner", 32'(ack_q[$]), 32'd2);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
